axi4_addr_arbiter: RTL and testbench
====================================

Name: axi4_addr_arbiter

Overview:
- N-port AXI4 address-channel arbiter. It is the parametrised successor of the two-input AW/AR mux.
- It merges NPORT independent address request channels onto one Efinix AXI4-modified A channel toward the DDR controller. Each port carries its own read/write type.
- Arbitration is round-robin or fixed priority. Fixed priority has a starvation guard.
- A registered output slice sustains one grant per cycle with no idle bubble between grants.

Parameters:
- NPORT, 4, number of request ports (2..16)
- AID_LEN, 8, ID width
- AADDR_LEN, 32, address width
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lower index wins)
- MAX_GRANT, 4, fixed mode only: maximum consecutive grants to one port while another port waits (1..255)
- PORT_W, 2, width of the port index; must be at least max(1, clog2(NPORT))

Ports:
- aclk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- req_id_i  in  NPORT*AID_LEN  per-port ID, port k at slice [k*AID_LEN +: AID_LEN]
- req_addr_i  in  NPORT*AADDR_LEN  per-port address
- req_len_i  in  NPORT*8  per-port burst length
- req_type_i  in  NPORT  1 = DDR write, 0 = DDR read
- req_valid_i  in  NPORT  per-port request valid
- req_ready_o  out  NPORT  per-port accept, one-hot or zero
- aid_o  out  AID_LEN  granted ID
- aaddr_o  out  AADDR_LEN  granted address
- alen_o  out  8  granted length
- atype_o  out  1  granted type, 1 = write
- aport_o  out  PORT_W  index of the granted port
- avalid_o  out  1  A-channel valid
- aready_i  in  1  A-channel ready

Behaviour:
- Reset (asynchronous, on arst_n_i low):
  - avalid_o, aid_o, aaddr_o, alen_o, atype_o and aport_o all go to 0.
  - The round-robin pointer and the consecutive-grant counter go to 0.
  - An entry held in the slice when reset hits mid-operation is dropped; nothing is replayed after release.
  - req_ready_o is 0 while reset is asserted.
- Slice free condition: free = !avalid_o || aready_i.
- Grant:
  - When free and any req_valid_i is high, exactly one winner k is chosen in the same cycle.
  - req_ready_o[k] = 1 combinationally in that cycle. This depends on valid, which is legal.
  - On the clock edge the winner's id/addr/len/type and k are loaded and avalid_o = 1.
  - Latency is 1 cycle from handshake to avalid_o.
  - When free and no request is valid, avalid_o goes to 0 on the next edge.
- Hold: while avalid_o = 1 and aready_i = 0, all A outputs stay stable and req_ready_o = 0.
- Back-to-back: when avalid_o = 1, aready_i = 1 and a request is valid, a new grant loads in the same cycle. Throughput is 1 per cycle.
- Round-robin (ARB_MODE = 0):
  - Search starts at pointer p, wrapping from NPORT-1 to 0.
  - On each grant to k, p = (k+1) mod NPORT.
  - After reset p = 0, so port 0 has first priority.
- Fixed priority (ARB_MODE = 1):
  - The lowest valid index wins.
  - The counter counts consecutive grants to the same port; a grant to a different port resets it to 1.
  - When the counter equals MAX_GRANT and some other port is valid, the last-granted port is masked for one arbitration and the counter resets.
  - The mask is ignored when the masked port is the only valid one.
- Simultaneous events:
  - Several valids in one cycle produce one grant only.
  - A port deasserting valid before it is granted is never granted.
- Type is per request. Mixed read/write ordering follows arbitration only; no read/write alternation is imposed.

Test Plan:
- Reset and idle: arst_n_i low mid-burst with avalid_o = 1 -> avalid_o = 0 immediately. After release with no valids -> req_ready_o = 0 and avalid_o = 0 for 10 cycles.
- RR fairness: NPORT = 4, all valid continuously, aready_i = 1 -> aport_o sequence 0,1,2,3,0,1; avalid_o high every cycle from cycle 1.
- Backpressure: aready_i = 0 for 5 cycles after a grant of port 2 (addr 0x1000, len 15, type 1) -> outputs stable, req_ready_o = 0. On aready_i = 1 the next grant goes to port 3 in the same cycle.
- Fixed priority with guard: ARB_MODE = 1, MAX_GRANT = 2, ports 0 and 3 always valid -> aport_o sequence 0,0,3,0,0,3.
- Sole requester: ARB_MODE = 1, only port 1 valid for 6 cycles -> 6 consecutive grants to port 1; the mask is not applied.
- Random scoreboard: random valids, types and aready_i over 10k cycles -> every accepted request appears exactly once on the A channel, in grant order, with matching id/addr/len/type/port.

Source files
------------

// File: rtl/axi4_addr_arbiter.sv
// N-port AXI4 address-channel arbiter: round-robin or fixed priority with a starvation guard,
// merging per-port requests into one registered A-channel slice that sustains one grant per cycle.
module axi4_addr_arbiter #(
  parameter int unsigned NPORT     = 4,
  parameter int unsigned AID_LEN   = 8,
  parameter int unsigned AADDR_LEN = 32,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned MAX_GRANT = 4,
  parameter int unsigned PORT_W    = 2
) (
  input  logic                       aclk_i,
  input  logic                       arst_n_i,
  input  logic [NPORT*AID_LEN-1:0]   req_id_i,
  input  logic [NPORT*AADDR_LEN-1:0] req_addr_i,
  input  logic [NPORT*8-1:0]         req_len_i,
  input  logic [NPORT-1:0]           req_type_i,
  input  logic [NPORT-1:0]           req_valid_i,
  output logic [NPORT-1:0]           req_ready_o,
  output logic [AID_LEN-1:0]         aid_o,
  output logic [AADDR_LEN-1:0]       aaddr_o,
  output logic [7:0]                 alen_o,
  output logic                       atype_o,
  output logic [PORT_W-1:0]          aport_o,
  output logic                       avalid_o,
  input  logic                       aready_i
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [AID_LEN-1:0]   aid;
    logic [AADDR_LEN-1:0] aaddr;
    logic [LEN_W-1:0]     alen;
    logic                 atype;
    logic [PORT_W-1:0]    aport;
  } a_beat_t;

  a_beat_t           r_beat;
  logic              r_avalid;
  logic [PORT_W-1:0] r_ptr;
  logic [PORT_W-1:0] r_last;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_free;
  logic              w_guard;
  logic [NPORT-1:0]  w_others;
  logic [NPORT-1:0]  w_cand;
  logic [NPORT-1:0]  w_rot;
  logic              w_hit;
  logic [PORT_W-1:0] w_win;
  logic [PORT_W-1:0] w_ptr_nxt;
  logic              w_grant;
  a_beat_t           w_sel;

  assign w_free   = !r_avalid || aready_i;
  assign w_others = req_valid_i & ~(NPORT'(1) << r_last);
  // Starvation guard: skip the last winner once it hit its grant budget, unless it is alone
  assign w_guard  = (ARB_MODE == 1) && (r_cnt == CNT_W'(MAX_GRANT)) && (|w_others);
  assign w_cand   = w_guard ? w_others : req_valid_i;
  assign w_grant  = w_free && w_hit;

  // Winner search: rotated-by-pointer scan for round-robin, plain lowest-index for fixed
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_rot = NPORT'({w_cand, w_cand} >> r_ptr);
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (!w_hit && w_rot[i]) begin
          w_hit = 1'b1;
          w_win = PORT_W'((32'(r_ptr) + i) % NPORT);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (!w_hit && w_cand[i]) begin
          w_hit = 1'b1;
          w_win = PORT_W'(i);
        end
      end
    end
  end

  // Payload mux for the winning port
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (w_win == PORT_W'(i)) begin
        w_sel.aid   = req_id_i[i*AID_LEN +: AID_LEN];
        w_sel.aaddr = req_addr_i[i*AADDR_LEN +: AADDR_LEN];
        w_sel.alen  = req_len_i[i*LEN_W +: LEN_W];
        w_sel.atype = req_type_i[i];
      end
    end
    w_sel.aport = w_win;
  end

  assign w_ptr_nxt   = (w_win == PORT_W'(NPORT - 1)) ? '0 : w_win + PORT_W'(1);
  assign req_ready_o = (w_grant && arst_n_i) ? (NPORT'(1) << w_win) : '0;

  // Output slice: loads whenever free; empties when free with nothing to grant
  always_ff @(posedge aclk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_avalid <= 1'b0;
      r_beat   <= '0;
    end else if (w_free) begin
      r_avalid <= w_hit;
      if (w_hit) begin
        r_beat <= w_sel;
      end
    end
  end

  // Arbitration history: round-robin pointer and saturating consecutive-grant counter
  always_ff @(posedge aclk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ptr  <= '0;
      r_last <= '0;
      r_cnt  <= '0;
    end else if (w_grant) begin
      r_ptr  <= w_ptr_nxt;
      r_last <= w_win;
      if (w_win != r_last) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != CNT_W'(MAX_GRANT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign avalid_o = r_avalid;
  assign aid_o    = r_beat.aid;
  assign aaddr_o  = r_beat.aaddr;
  assign alen_o   = r_beat.alen;
  assign atype_o  = r_beat.atype;
  assign aport_o  = r_beat.aport;

endmodule

// File: tb/tb_axi4_addr_arbiter.sv
// Bench for axi4_addr_arbiter: a round-robin and a fixed-priority instance share stimulus,
// directed scenarios plus a random run checked against a per-instance reference model.
module tb_axi4_addr_arbiter;

  localparam int NPORT     = 4;
  localparam int AID_LEN   = 8;
  localparam int AADDR_LEN = 32;
  localparam int PORT_W    = 2;
  localparam int MAX_GRANT = 2;
  localparam int BEAT_W    = 1 + AID_LEN + AADDR_LEN + 8 + 1 + PORT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       arst_n;
  logic [NPORT*AID_LEN-1:0]   req_id;
  logic [NPORT*AADDR_LEN-1:0] req_addr;
  logic [NPORT*8-1:0]         req_len;
  logic [NPORT-1:0]           req_type;
  logic [NPORT-1:0]           req_valid;
  logic                       aready;

  logic [NPORT-1:0]     ready  [2];
  logic [AID_LEN-1:0]   aid    [2];
  logic [AADDR_LEN-1:0] aaddr  [2];
  logic [7:0]           alen   [2];
  logic                 atype  [2];
  logic [PORT_W-1:0]    aport  [2];
  logic                 avalid [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed-priority instance
  logic                 e_valid [2];
  logic [AID_LEN-1:0]   e_id    [2];
  logic [AADDR_LEN-1:0] e_addr  [2];
  logic [7:0]           e_len   [2];
  logic                 e_type  [2];
  logic [PORT_W-1:0]    e_port  [2];
  int                   m_ptr   [2];
  int                   m_last  [2];
  int                   m_cnt   [2];

  axi4_addr_arbiter #(
    .NPORT(NPORT), .AID_LEN(AID_LEN), .AADDR_LEN(AADDR_LEN),
    .ARB_MODE(0), .MAX_GRANT(MAX_GRANT), .PORT_W(PORT_W)
  ) u_rr (
    .aclk_i(clk), .arst_n_i(arst_n),
    .req_id_i(req_id), .req_addr_i(req_addr), .req_len_i(req_len),
    .req_type_i(req_type), .req_valid_i(req_valid), .req_ready_o(ready[0]),
    .aid_o(aid[0]), .aaddr_o(aaddr[0]), .alen_o(alen[0]), .atype_o(atype[0]),
    .aport_o(aport[0]), .avalid_o(avalid[0]), .aready_i(aready)
  );

  axi4_addr_arbiter #(
    .NPORT(NPORT), .AID_LEN(AID_LEN), .AADDR_LEN(AADDR_LEN),
    .ARB_MODE(1), .MAX_GRANT(MAX_GRANT), .PORT_W(PORT_W)
  ) u_fp (
    .aclk_i(clk), .arst_n_i(arst_n),
    .req_id_i(req_id), .req_addr_i(req_addr), .req_len_i(req_len),
    .req_type_i(req_type), .req_valid_i(req_valid), .req_ready_o(ready[1]),
    .aid_o(aid[1]), .aaddr_o(aaddr[1]), .alen_o(alen[1]), .atype_o(atype[1]),
    .aport_o(aport[1]), .avalid_o(avalid[1]), .aready_i(aready)
  );

  function automatic logic [BEAT_W-1:0] beat_of(input int m);
    return {avalid[m], aid[m], aaddr[m], alen[m], atype[m], aport[m]};
  endfunction

  // Winner under the arbitration rules, -1 when nothing is valid
  function automatic int pick(input int m, input logic [NPORT-1:0] v);
    logic [NPORT-1:0] cand;
    if (v == '0) return -1;
    if (m == 0) begin
      for (int i = 0; i < NPORT; i++) begin
        int k;
        k = (m_ptr[m] + i) % NPORT;
        if (v[k]) return k;
      end
      return -1;
    end
    cand = v;
    if (m_cnt[m] == MAX_GRANT && (v & ~(NPORT'(1) << m_last[m])) != '0) cand[m_last[m]] = 1'b0;
    for (int i = 0; i < NPORT; i++) if (cand[i]) return i;
    return -1;
  endfunction

  task automatic randomize_payload();
    for (int k = 0; k < NPORT; k++) begin
      req_id[k*AID_LEN +: AID_LEN]       = AID_LEN'($urandom);
      req_addr[k*AADDR_LEN +: AADDR_LEN] = AADDR_LEN'($urandom);
      req_len[k*8 +: 8]                  = 8'($urandom);
      req_type[k]                        = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    arst_n    = 1'b0;
    req_valid = '0;
    aready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n    = 1'b1;
    aready    = 1'b0;
    req_valid = '1;
    randomize_payload();
    #1 arst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (beat_of(m) !== '0) $display("FAIL reset_out[%0d]: got %h expected 0", m, beat_of(m));
      else n_pass++;
      n_checks++;
      if (ready[m] !== '0) $display("FAIL reset_ready[%0d]: got %b expected 0", m, ready[m]);
      else n_pass++;
    end
    req_valid = '0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset_midburst();
    do_reset();
    randomize_payload();
    req_valid = '1;
    @(negedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (avalid[m] !== 1'b1) $display("FAIL midrst_pre[%0d]: avalid %b expected 1", m, avalid[m]);
      else n_pass++;
    end
    arst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if ({avalid[m], ready[m]} !== '0)
        $display("FAIL midrst_drop[%0d]: avalid %b ready %b expected 0/0", m, avalid[m], ready[m]);
      else n_pass++;
    end
    @(negedge clk);
    req_valid = '0;
    arst_n    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if ({avalid[m], ready[m]} !== '0)
          $display("FAIL idle[%0d] cyc %0d: avalid %b ready %b expected 0/0", m, c, avalid[m], ready[m]);
        else n_pass++;
      end
    end
    req_valid = '1;
    aready    = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({avalid[0], aport[0]} !== {1'b1, 2'd0})
      $display("FAIL rr_ptr_reset: avalid %b port %0d expected 1/0", avalid[0], aport[0]);
    else n_pass++;
  endtask

  task automatic test_rr_fairness();
    do_reset();
    randomize_payload();
    req_valid = '1;
    aready    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int er;
      int ef;
      er = i % NPORT;
      ef = (i % 3 == 2) ? 1 : 0;
      @(negedge clk); #1;
      n_checks++;
      if ({avalid[0], aport[0], aid[0]} !== {1'b1, PORT_W'(er), req_id[er*AID_LEN +: AID_LEN]})
        $display("FAIL rr_seq[%0d]: avalid %b port %0d id %h expected port %0d", i, avalid[0], aport[0], aid[0], er);
      else n_pass++;
      n_checks++;
      if ({avalid[1], aport[1]} !== {1'b1, PORT_W'(ef)})
        $display("FAIL fp_allvalid_seq[%0d]: avalid %b port %0d expected port %0d", i, avalid[1], aport[1], ef);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [BEAT_W-1:0] exp_b;
    do_reset();
    randomize_payload();
    req_id[2*AID_LEN +: AID_LEN]       = 8'hA5;
    req_addr[2*AADDR_LEN +: AADDR_LEN] = 32'h0000_1000;
    req_len[2*8 +: 8]                  = 8'd15;
    req_type[2]                        = 1'b1;
    req_valid = 4'b0100;
    aready    = 1'b0;
    #1;
    n_checks++;
    if (ready[0] !== 4'b0100) $display("FAIL bp_first_ready: got %b expected 0100", ready[0]);
    else n_pass++;
    @(negedge clk);
    req_valid = 4'b1011;
    #1;
    exp_b = {1'b1, 8'hA5, 32'h0000_1000, 8'd15, 1'b1, 2'd2};
    for (int c = 0; c < 5; c++) begin
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (beat_of(m) !== exp_b) $display("FAIL bp_hold[%0d] cyc %0d: got %h expected %h", m, c, beat_of(m), exp_b);
        else n_pass++;
        n_checks++;
        if (ready[m] !== '0) $display("FAIL bp_ready[%0d] cyc %0d: got %b expected 0", m, c, ready[m]);
        else n_pass++;
      end
      @(negedge clk); #1;
    end
    aready = 1'b1;
    #1;
    n_checks++;
    if (ready[0] !== 4'b1000) $display("FAIL bp_release_rr: ready %b expected 1000", ready[0]);
    else n_pass++;
    n_checks++;
    if (ready[1] !== 4'b0001) $display("FAIL bp_release_fp: ready %b expected 0001", ready[1]);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({avalid[0], aport[0], aaddr[0]} !== {1'b1, 2'd3, req_addr[3*AADDR_LEN +: AADDR_LEN]})
      $display("FAIL bp_next_rr: avalid %b port %0d addr %h expected port 3", avalid[0], aport[0], aaddr[0]);
    else n_pass++;
    n_checks++;
    if ({avalid[1], aport[1]} !== {1'b1, 2'd0})
      $display("FAIL bp_next_fp: avalid %b port %0d expected port 0", avalid[1], aport[1]);
    else n_pass++;
    req_valid = '0;
    @(negedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (avalid[m] !== 1'b0) $display("FAIL bp_drain[%0d]: avalid %b expected 0", m, avalid[m]);
      else n_pass++;
    end
  endtask

  task automatic test_fixed_guard();
    do_reset();
    randomize_payload();
    req_valid = 4'b1001;
    aready    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int ef;
      int er;
      ef = (i % 3 == 2) ? 3 : 0;
      er = (i % 2 == 1) ? 3 : 0;
      @(negedge clk); #1;
      n_checks++;
      if ({avalid[1], aport[1]} !== {1'b1, PORT_W'(ef)})
        $display("FAIL fp_guard[%0d]: avalid %b port %0d expected port %0d", i, avalid[1], aport[1], ef);
      else n_pass++;
      n_checks++;
      if ({avalid[0], aport[0]} !== {1'b1, PORT_W'(er)})
        $display("FAIL rr_two[%0d]: avalid %b port %0d expected port %0d", i, avalid[0], aport[0], er);
      else n_pass++;
    end
  endtask

  task automatic test_sole();
    do_reset();
    randomize_payload();
    req_valid = 4'b0010;
    aready    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if ({avalid[m], aport[m]} !== {1'b1, 2'd1})
          $display("FAIL sole[%0d] cyc %0d: avalid %b port %0d expected port 1", m, i, avalid[m], aport[m]);
        else n_pass++;
      end
    end
    req_valid = 4'b0110;
    @(negedge clk); #1;
    n_checks++;
    if ({avalid[1], aport[1]} !== {1'b1, 2'd2})
      $display("FAIL sole_guard_after: avalid %b port %0d expected port 2", avalid[1], aport[1]);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({avalid[1], aport[1]} !== {1'b1, 2'd1})
      $display("FAIL sole_return: avalid %b port %0d expected port 1", avalid[1], aport[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      e_valid[m] = 1'b0;
      m_ptr[m]   = 0;
      m_last[m]  = 0;
      m_cnt[m]   = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      randomize_payload();
      for (int k = 0; k < NPORT; k++) req_valid[k] = ($urandom_range(0, 9) < 6);
      aready = ($urandom_range(0, 9) < 6);
      #1;
      for (int m = 0; m < 2; m++) begin
        logic             free;
        int               k;
        logic [NPORT-1:0] exp_r;
        logic [BEAT_W-1:0] exp_b;
        exp_b = {1'b1, e_id[m], e_addr[m], e_len[m], e_type[m], e_port[m]};
        n_checks++;
        if (e_valid[m] ? (beat_of(m) !== exp_b) : (avalid[m] !== 1'b0))
          $display("FAIL rand_out[%0d] cyc %0d: got %h expected %h (valid %b)", m, c, beat_of(m), exp_b, e_valid[m]);
        else n_pass++;
        free  = !e_valid[m] || aready;
        k     = free ? pick(m, req_valid) : -1;
        exp_r = (k >= 0) ? (NPORT'(1) << k) : '0;
        n_checks++;
        if (ready[m] !== exp_r) $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", m, c, ready[m], exp_r);
        else n_pass++;
        if (free) begin
          if (k >= 0) begin
            e_valid[m] = 1'b1;
            e_id[m]    = req_id[k*AID_LEN +: AID_LEN];
            e_addr[m]  = req_addr[k*AADDR_LEN +: AADDR_LEN];
            e_len[m]   = req_len[k*8 +: 8];
            e_type[m]  = req_type[k];
            e_port[m]  = PORT_W'(k);
            m_ptr[m]   = (k + 1) % NPORT;
            if (k == m_last[m]) m_cnt[m] = (m_cnt[m] < MAX_GRANT) ? m_cnt[m] + 1 : m_cnt[m];
            else m_cnt[m] = 1;
            m_last[m] = k;
          end else begin
            e_valid[m] = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midburst();
    test_rr_fairness();
    test_backpressure();
    test_fixed_guard();
    test_sole();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
